// File: rtl/cbus_arbiter.sv
`default_nettype none
// cbus_arbiter -- round-robin arbiter that locks one cbus port to a requester for a whole transaction.
// Rev 1.0
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       iresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx,
  output logic             proto_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [SEL_W:0]   NUM_REQ_W = (SEL_W + 1)'(NUM_REQ);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REQ - 1);

  state_t           state;
  state_t           state_next;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_next;
  logic [SEL_W-1:0] grant_next;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             err_next;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin : pick
    logic [SEL_W:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!pick_found && ireqs[cand[SEL_W-1:0]].valid) begin
        pick_found = 1'b1;
        pick_idx   = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant_idx;
    rr_next    = rr_ptr;
    err_next   = proto_err;
    oreq       = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      iresps[j] = '0;
    end
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          state_next = BUSY;
        end
      end
      BUSY: begin
        oreq              = ireqs[grant_idx];
        iresps[grant_idx] = oresp;
        // A requester dropping valid mid-transaction is flagged, but the
        // downstream burst still runs to its last beat.
        if (!ireqs[grant_idx].valid) begin
          err_next = 1'b1;
        end
        if (oresp.ready && oresp.last) begin
          state_next = IDLE;
          rr_next    = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      rr_ptr    <= rr_next;
      grant_idx <= grant_next;
      proto_err <= err_next;
    end
  end

  assign grant_valid = (state == BUSY);

endmodule
`default_nettype wire

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares one cbus port, the memory side of the RAM model / AXI bridge, between NUM_REQ cbus requesters such as the icache refill, dcache refill/writeback and uncached MMIO.
- Grants whole transactions and keeps the grant locked until the last response beat.
- Arbitration is round-robin.
- Sits between the cache controllers and the memory helper in the core's top-level.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..8).
- SEL_W, $clog2(NUM_REQ) (min 1), width of the grant index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ireqs  in  cbus_req_t[NUM_REQ]  upstream requests. Fields: valid, is_write, size, addr, len, burst, strobe, data.
- iresps  out  cbus_resp_t[NUM_REQ]  upstream responses. Fields: ready, last, data.
- oreq  out  cbus_req_t  downstream request.
- oresp  in  cbus_resp_t  downstream response.
- grant_valid  out  1  a transaction is currently granted.
- grant_idx  out  SEL_W  index of the granted requester.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset==0, asynchronous) drives:
  - state=IDLE, rr_ptr=0, grant_idx=0, grant_valid=0, proto_err=0.
  - oreq='0.
  - all iresps='0.
- Reset asserted mid-transaction aborts immediately: oreq.valid drops in the same cycle. The downstream memory model is reset together with the arbiter.
- State machine has 2 states, IDLE and BUSY.
- IDLE:
  - oreq='0, all iresps='0.
  - If any ireqs[i].valid: choose the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register that index into grant_idx; state<=BUSY.
  - Arbitration latency: 1 cycle from valid to oreq.valid.
- BUSY:
  - oreq = ireqs[grant_idx], combinational pass-through.
  - iresps[grant_idx] = oresp; every other iresps[j]='0.
  - A beat completes when oresp.ready==1.
  - On oresp.ready && oresp.last: state<=IDLE, rr_ptr<=(grant_idx+1) mod NUM_REQ.
  - IDLE then forces oreq.valid=0 for at least 1 cycle between transactions. This gives the memory model's NONE state a clean valid edge.
- grant_valid = (state==BUSY); grant_idx is held stable throughout BUSY.
- Requests from non-granted requesters are ignored and receive no response. Their requester must keep valid high until granted.
- Protocol check: in BUSY, if ireqs[grant_idx].valid==0 before the last beat completes, set proto_err<=1.
  - proto_err stays set until reset.
  - The transaction continues to the downstream last beat. oreq.valid follows the requester (0), and the arbiter still waits for oresp.last.
- Simultaneous events:
  - Last beat plus new valid requests in the same cycle: the arbiter goes to IDLE and arbitrates next cycle, with rr_ptr already advanced.
  - A requester whose transaction just ended and which re-asserts valid immediately loses to any other waiting requester.
- rr_ptr wrap-around: grant_idx==NUM_REQ-1 gives rr_ptr=0.
- NUM_REQ==1 degenerates to a 1-cycle-bubble pass-through with SEL_W=1 and grant_idx constant 0.
- No combinational path from oresp to oreq.

Test Plan:
1. Single read, NUM_REQ=2.
   - Stimulus: ireqs[0] read, addr 0x8000_0000, len=3, burst INCR, size=3.
   - Required: grant_idx=0; oreq.valid rises exactly 1 cycle after ireqs[0].valid; 4 beats on iresps[0]; iresps[1] stays 0; IDLE after the last beat; rr_ptr=1.
2. Simultaneous requests.
   - Stimulus: ireqs[0] and ireqs[1] valid together from reset, both held.
   - Required: 0 served first, then 1, then 0 again. Exactly 1 idle cycle with oreq.valid=0 between grants.
3. Write burst to 0x8000_1000, len=1, strobe=0xFF, from ireqs[1].
   - Required: oreq.data/strobe mirror ireqs[1]; 2 beats; reading the address back through ireqs[0] returns the written data.
4. Wrap-around, NUM_REQ=3.
   - Stimulus: all three requesters valid continuously.
   - Required: grant order 0,1,2,0,1,2; no requester is granted twice before the others are served.
5. Protocol error.
   - Stimulus: ireqs[0] drops valid after beat 1 of a len=3 read.
   - Required: proto_err=1 next cycle and sticky; arbiter returns to IDLE only after oresp.last.
6. Reset mid-burst.
   - Stimulus: reset=0 asserted asynchronously during beat 2.
   - Required: oreq.valid=0 and grant_valid=0 without waiting for a clock edge; after release, the first grant goes to index 0.
